// File: rtl/reg_scoreboard.sv
// Register scoreboard: a 2-bit pending-write counter per GPR 1..31 drives the ID-stage stall.
// Define SCOREBOARD_WB_BYPASS_EN to let a same-cycle WB retire clear a last-pending RAW hazard.
module reg_scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic       reg_read_en_1,
  input  logic [4:0] reg_addr_1,
  input  logic       reg_read_en_2,
  input  logic [4:0] reg_addr_2,
  input  logic       reg_write_en,
  input  logic [4:0] reg_write_addr,
  input  logic       retire_valid,
  input  logic [4:0] retire_addr,
  input  logic       flush,
  output logic       stall,
  output logic       busy,
  output logic [6:0] outstanding,
  output logic       err
);

  logic [1:0] cnt_q [32];
  logic [1:0] cnt_d [32];
  logic       busy_q, busy_d;
  logic [6:0] out_q, out_d;
  logic       err_q, err_d;

  logic hz_1, hz_2, sat, byp_1, byp_2;
  logic inc, dec, inc_i, dec_i;

  // Hazard / saturation detection against the registered counters.
  always_comb begin
    byp_1 = 1'b0;
    byp_2 = 1'b0;
`ifdef SCOREBOARD_WB_BYPASS_EN
    byp_1 = retire_valid && (retire_addr == reg_addr_1) && (cnt_q[reg_addr_1] == 2'd1);
    byp_2 = retire_valid && (retire_addr == reg_addr_2) && (cnt_q[reg_addr_2] == 2'd1);
`endif
    hz_1  = reg_read_en_1 && (reg_addr_1 != 5'd0) && (cnt_q[reg_addr_1] != 2'd0) && !byp_1;
    hz_2  = reg_read_en_2 && (reg_addr_2 != 5'd0) && (cnt_q[reg_addr_2] != 2'd0) && !byp_2;
    sat   = reg_write_en && (reg_write_addr != 5'd0) && (cnt_q[reg_write_addr] == 2'd3);
    stall = hz_1 || hz_2 || sat;
  end

  always_comb begin
    inc   = issue_valid && !stall && reg_write_en && (reg_write_addr != 5'd0);
    dec   = retire_valid && (retire_addr != 5'd0);
    inc_i = 1'b0;
    dec_i = 1'b0;
    err_d = err_q;
    out_d = '0;
    cnt_d[0] = '0;
    for (int i = 1; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      inc_i    = inc && (reg_write_addr == 5'(i));
      dec_i    = dec && (retire_addr == 5'(i));
      // Issue and retire to the same register cancel; a retire never underflows.
      if (inc_i && !dec_i) begin
        cnt_d[i] = cnt_q[i] + 2'd1;
      end else if (dec_i && !inc_i && (cnt_q[i] != 2'd0)) begin
        cnt_d[i] = cnt_q[i] - 2'd1;
      end
      if (flush) begin
        cnt_d[i] = '0;
      end
      out_d = out_d + 7'(cnt_d[i]);
    end
    if (dec && !flush && (cnt_q[retire_addr] == 2'd0)) begin
      err_d = 1'b1;
    end
    busy_d = (out_d != 7'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= '0;
      end
      busy_q <= 1'b0;
      out_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      out_q  <= out_d;
      err_q  <= err_d;
    end
  end

  assign busy        = busy_q;
  assign outstanding = out_q;
  assign err         = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vector table, reset corner cases, then
// randomized traffic against a per-register pending-count model.
module tb_reg_scoreboard;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, reg_read_en_1, reg_read_en_2, reg_write_en, retire_valid, flush;
  logic [4:0] reg_addr_1, reg_addr_2, reg_write_addr, retire_addr;
  logic       stall, busy, err;
  logic [6:0] outstanding;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .reg_read_en_1 (reg_read_en_1),
    .reg_addr_1    (reg_addr_1),
    .reg_read_en_2 (reg_read_en_2),
    .reg_addr_2    (reg_addr_2),
    .reg_write_en  (reg_write_en),
    .reg_write_addr(reg_write_addr),
    .retire_valid  (retire_valid),
    .retire_addr   (retire_addr),
    .flush         (flush),
    .stall         (stall),
    .busy          (busy),
    .outstanding   (outstanding),
    .err           (err)
  );

  typedef struct {
    logic       iv;
    logic       r1;
    logic [4:0] a1;
    logic       r2;
    logic [4:0] a2;
    logic       we;
    logic [4:0] wa;
    logic       rv;
    logic [4:0] ra;
    logic       fl;
    logic       e_stall;
    int         e_out;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic iv, logic r1, int a1, logic r2, int a2, logic we, int wa,
                             logic rv, int ra, logic fl, logic e_stall, int e_out, logic e_err);
    vec_t t;
    t.iv = iv; t.r1 = r1; t.a1 = 5'(a1); t.r2 = r2; t.a2 = 5'(a2);
    t.we = we; t.wa = 5'(wa); t.rv = rv; t.ra = 5'(ra); t.fl = fl;
    t.e_stall = e_stall; t.e_out = e_out; t.e_err = e_err;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    issue_valid = t.iv; reg_read_en_1 = t.r1; reg_addr_1 = t.a1;
    reg_read_en_2 = t.r2; reg_addr_2 = t.a2; reg_write_en = t.we; reg_write_addr = t.wa;
    retire_valid = t.rv; retire_addr = t.ra; flush = t.fl;
  endtask

  task automatic check_regs(input string nm, input int e_out, input logic e_err);
    chk({nm, ".outstanding"}, int'(outstanding), e_out);
    chk({nm, ".busy"}, int'(busy), int'(e_out != 0));
    chk({nm, ".err"}, int'(err), int'(e_err));
  endtask

  // Reference model: pending writes per register, plus the sticky error.
  int   m_cnt[32];
  logic m_err;

  function automatic logic m_hazard(logic re, logic [4:0] a);
    if (!re || a == 5'd0 || m_cnt[a] == 0) return 1'b0;
    if (Byp && retire_valid && retire_addr == a && m_cnt[a] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_stall();
    return m_hazard(reg_read_en_1, reg_addr_1) || m_hazard(reg_read_en_2, reg_addr_2) ||
           (reg_write_en && reg_write_addr != 5'd0 && m_cnt[reg_write_addr] == 3);
  endfunction

  function automatic int m_total();
    int s = 0;
    for (int i = 0; i < 32; i++) s += m_cnt[i];
    return s;
  endfunction

  task automatic m_update(input logic st);
    logic inc, dec;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_err = 1'b0;
    end else if (flush) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    end else begin
      inc = issue_valid && !st && reg_write_en && reg_write_addr != 5'd0;
      dec = retire_valid && retire_addr != 5'd0;
      if (dec && m_cnt[retire_addr] == 0) m_err = 1'b1;
      if (!(inc && dec && reg_write_addr == retire_addr)) begin
        if (inc) m_cnt[reg_write_addr]++;
        if (dec && m_cnt[retire_addr] > 0) m_cnt[retire_addr]--;
      end
    end
  endtask

  initial begin
    vec_t idle;
    logic st;
    idle = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Directed sequence, in order; each row is one cycle.
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // idle
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 1, 0));   // issue write $5
    tbl.push_back(v(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));   // RAW on $5
    tbl.push_back(v(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(v(1, 1, 5, 0, 0, 0, 0, 1, 5, 0, !Byp, 0, 0)); // retire $5
    tbl.push_back(v(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 1, 0));   // saturate $7
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 2, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 3, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 3, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 7, 1, 7, 0, 1, 2, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 3, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));   // flush
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 1, 0));   // $9 -> 1
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 9, 1, 9, 0, 0, 1, 0));   // issue+retire $9
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1));   // underflow $3
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));   // err survives flush
    tbl.push_back(v(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1));   // $0 everywhere
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 4, 0, 0, 1, 0, 0, 1));   // flush beats issue $4
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 1, 1, 1));   // RAW on port 2
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));

    rst = 1'b1;
    drive(idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("reset.stall", int'(stall), 0);
    check_regs("reset", 0, 1'b0);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1 chk($sformatf("vec%0d.stall", i), int'(stall), int'(tbl[i].e_stall));
      @(posedge clk);
      #1 check_regs($sformatf("vec%0d", i), tbl[i].e_out, tbl[i].e_err);
    end

    // Reset wins over issue and clears the sticky error.
    @(negedge clk);
    drive(v(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 check_regs("pre_rst", 1, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    drive(v(1, 0, 0, 0, 0, 1, 6, 1, 3, 0, 0, 0, 0));
    @(posedge clk);
    #1 check_regs("rst_prio", 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(v(1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 chk("post_rst.stall", int'(stall), 0);
    @(posedge clk);
    #1 check_regs("post_rst", 0, 1'b0);

    // Randomized traffic on a narrow address range to provoke hazards and saturation.
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_err = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst            = ($urandom_range(0, 299) == 0);
      issue_valid    = $urandom_range(0, 3) != 0;
      reg_read_en_1  = $urandom_range(0, 1) != 0;
      reg_addr_1     = 5'($urandom_range(0, 6));
      reg_read_en_2  = $urandom_range(0, 1) != 0;
      reg_addr_2     = 5'($urandom_range(0, 6));
      reg_write_en   = $urandom_range(0, 3) != 0;
      reg_write_addr = 5'($urandom_range(0, 6));
      retire_valid   = $urandom_range(0, 2) == 0;
      retire_addr    = 5'($urandom_range(0, 6));
      flush          = ($urandom_range(0, 39) == 0);
      if (flush) retire_valid = 1'b0;
      #1;
      st = m_stall();
      chk($sformatf("rnd%0d.stall", n), int'(stall), int'(st));
      @(posedge clk);
      m_update(st);
      #1 check_regs($sformatf("rnd%0d", n), m_total(), m_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
